// File: rtl/pe_row_drain_if.sv
// pe_row_drain_if: beat stream from the row drain controller to the memory writer.
// master drives m_valid/m_data/m_idx/m_last; slave drives m_ready.
interface pe_row_drain_if #(
    parameter int N     = 4,
    parameter int DEPTH = 4
);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic              m_valid;
    logic              m_ready;
    logic [N*32-1:0]   m_data;
    logic [IW-1:0]     m_idx;
    logic              m_last;

    modport master (
        output m_valid,
        output m_data,
        output m_idx,
        output m_last,
        input  m_ready
    );

    modport slave (
        input  m_valid,
        input  m_data,
        input  m_idx,
        input  m_last,
        output m_ready
    );
endinterface

// File: rtl/pe_row_drain.sv
// pe_row_drain: writeback drain controller for one row of N PEs.
// Walks each PE accumulator regfile, captures out_sum beats into a FIFO,
// and streams them to the memory writer.
//
// Ports:
//   clk, rst     clock, async active-high reset
//   start        one-cycle request to drain the row (honoured in IDLE only)
//   busy, done   drain in progress / one-cycle completion pulse
//   wben         writeback mode to all PEs
//   out_ready    read one entry and advance the PE pointer
//   out_sum      N*32 concatenated PE outputs
//   m            beat stream (master side of pe_row_drain_if)
//   stall_cnt    back-pressure cycle counter, present only when
//                PE_DRAIN_STALL_CNT_EN is defined
module pe_row_drain #(
    parameter int N          = 4,
    parameter int DEPTH      = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic            wben,
    output logic            out_ready,
    input  logic [N*32-1:0] out_sum,
`ifdef PE_DRAIN_STALL_CNT_EN
    output logic [15:0]     stall_cnt,
`endif
    pe_row_drain_if.master  m
);
    localparam int DW   = N * 32;
    localparam int IW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNTW = $clog2(DEPTH + 1);
    localparam int PW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int FW   = $clog2(FIFO_DEPTH + 1);

    localparam logic [CNTW-1:0] ISSUE_MAX = CNTW'(DEPTH);
    localparam logic [IW-1:0]   LAST_IDX  = IW'(DEPTH - 1);
    localparam logic [PW-1:0]   PTR_MAX   = PW'(FIFO_DEPTH - 1);
    localparam logic [FW:0]     FD_LIM    = (FW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRAIN,
        S_FLUSH
    } state_t;

    state_t          state_q;
    logic            busy_q;
    logic            done_q;
    logic            wben_q;
    logic            rdy_q;
    logic [CNTW-1:0] issue_q;
    logic            cap_v_q;
    logic [IW-1:0]   cap_idx_q;

    logic [DW-1:0]   mem_data_q [FIFO_DEPTH];
    logic [IW-1:0]   mem_idx_q  [FIFO_DEPTH];
    logic [PW-1:0]   wr_q;
    logic [PW-1:0]   rd_q;
    logic [FW-1:0]   cnt_q;
    logic [FW-1:0]   cnt_d;

    logic            start_acc;
    logic            push;
    logic            pop;
    logic [CNTW-1:0] issue_nx;
    logic [FW:0]     credit_sum;
    logic            credit_ok;

    assign start_acc = (state_q == S_IDLE) && start;
    assign push      = cap_v_q;
    assign pop       = m.m_valid && m.m_ready;
    assign issue_nx  = issue_q + CNTW'(rdy_q);

    always_comb begin
        cnt_d = cnt_q;
        if (start_acc) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + FW'(push) - FW'(pop);
        end
    end

    // out_ready is registered, so the credit check is evaluated on the
    // values the FIFO count and capture flag will hold next cycle; the
    // next-cycle pop is deliberately not credited.
    assign credit_sum = {1'b0, cnt_d} + (FW + 1)'(rdy_q);
    assign credit_ok  = credit_sum < FD_LIM;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            wben_q    <= 1'b0;
            rdy_q     <= 1'b0;
            issue_q   <= '0;
            cap_v_q   <= 1'b0;
            cap_idx_q <= '0;
        end else begin
            done_q    <= 1'b0;
            // PE presents the entry on the edge ending out_ready;
            // it is sampled one edge later.
            cap_v_q   <= rdy_q;
            cap_idx_q <= issue_q[IW-1:0];
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= S_DRAIN;
                        busy_q  <= 1'b1;
                        wben_q  <= 1'b1;
                        rdy_q   <= 1'b1;
                        issue_q <= '0;
                    end
                end
                S_DRAIN: begin
                    issue_q <= issue_nx;
                    rdy_q   <= (issue_nx < ISSUE_MAX) && credit_ok;
                    if (issue_q == ISSUE_MAX) begin
                        state_q <= S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    rdy_q <= 1'b0;
                    if (!cap_v_q &&
                        ((cnt_q == '0) ||
                         ((cnt_q == FW'(1)) && pop))) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        wben_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    wben_q  <= 1'b0;
                    rdy_q   <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (start_acc) begin
                wr_q <= '0;
                rd_q <= '0;
            end else begin
                if (push) begin
                    wr_q <= (wr_q == PTR_MAX) ? '0 : wr_q + PW'(1);
                end
                if (pop) begin
                    rd_q <= (rd_q == PTR_MAX) ? '0 : rd_q + PW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_data_q[wr_q] <= out_sum;
            mem_idx_q[wr_q]  <= cap_idx_q;
        end
    end

    // Head fields are gated by valid so the stream reads zero when empty.
    assign m.m_valid = (cnt_q != '0);
    assign m.m_data  = m.m_valid ? mem_data_q[rd_q] : '0;
    assign m.m_idx   = m.m_valid ? mem_idx_q[rd_q] : '0;
    assign m.m_last  = m.m_valid && (mem_idx_q[rd_q] == LAST_IDX);

    assign busy      = busy_q;
    assign done      = done_q;
    assign wben      = wben_q;
    assign out_ready = rdy_q;

`ifdef PE_DRAIN_STALL_CNT_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
        end else if (start_acc) begin
            stall_q <= '0;
        end else if (busy_q && m.m_valid && !m.m_ready &&
                     (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_cnt = stall_q;
`endif

endmodule
